// File: rtl/top_pkg.sv
// Shared widths, mode encoding and helpers for the registered 4-bit ALU.
// Optional multiplier is enabled by defining TOP_MUL_EN.
package top_pkg;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned RES_W  = 8;
    localparam int unsigned MODE_W = 4;

    typedef enum logic [MODE_W-1:0] {
        MODE_ADD  = 4'b0000,
        MODE_SUB  = 4'b0001,
        MODE_MUL  = 4'b0010,
        MODE_AND  = 4'b0011,
        MODE_OR   = 4'b0100,
        MODE_XOR  = 4'b0101,
        MODE_NAND = 4'b0110,
        MODE_NOR  = 4'b0111,
        MODE_XNOR = 4'b1000,
        MODE_SHL  = 4'b1001,
        MODE_SHR  = 4'b1010,
        MODE_ROL  = 4'b1011,
        MODE_ROR  = 4'b1100,
        MODE_GT   = 4'b1101,
        MODE_EQ   = 4'b1110,
        MODE_CLR  = 4'b1111
    } alu_mode_e;

    // Place a 4-bit operand-wide value in the low bits of a result word.
    function automatic logic [RES_W-1:0] zext(input logic [OP_W-1:0] v);
        return {{(RES_W-OP_W){1'b0}}, v};
    endfunction

endpackage

// File: rtl/top_alu_core.sv
// Combinational ALU datapath: computes the next result from operands and mode.
// The multiplier branch exists only when TOP_MUL_EN is defined.
module top_alu_core
    import top_pkg::*;
(
    input  logic [OP_W-1:0]   in1,
    input  logic [OP_W-1:0]   in2,
    input  logic [MODE_W-1:0] alu_mode,
    output logic [RES_W-1:0]  res_c
);

    alu_mode_e        mode;
    logic [RES_W-1:0] a_ext;
    logic [RES_W-1:0] b_ext;
    logic [1:0]       sh2;
    logic [2:0]       sh3;
    logic [RES_W-1:0] rot_l;
    logic [RES_W-1:0] rot_r;
    logic [OP_W-1:0]  lg;

    assign mode  = alu_mode_e'(alu_mode);
    assign a_ext = zext(in1);
    assign b_ext = zext(in2);
    assign sh2   = in2[1:0];
    assign sh3   = in2[2:0];
    // Rotations shift a doubled copy so the wrapped bits land in one nibble.
    assign rot_l = {in1, in1} << sh2;
    assign rot_r = {in1, in1} >> sh2;

    always_comb begin
        res_c = '0;
        lg    = '0;
        case (mode)
            MODE_ADD:  res_c = a_ext + b_ext;
            MODE_SUB:  res_c = a_ext - b_ext;
`ifdef TOP_MUL_EN
            MODE_MUL:  res_c = a_ext * b_ext;
`else
            MODE_MUL:  res_c = '0;
`endif
            MODE_AND:  begin lg = in1 & in2;    res_c = zext(lg); end
            MODE_OR:   begin lg = in1 | in2;    res_c = zext(lg); end
            MODE_XOR:  begin lg = in1 ^ in2;    res_c = zext(lg); end
            MODE_NAND: begin lg = ~(in1 & in2); res_c = zext(lg); end
            MODE_NOR:  begin lg = ~(in1 | in2); res_c = zext(lg); end
            MODE_XNOR: begin lg = ~(in1 ^ in2); res_c = zext(lg); end
            MODE_SHL:  res_c = a_ext << sh3;
            MODE_SHR:  begin lg = in1 >> sh2;   res_c = zext(lg); end
            MODE_ROL:  res_c = zext(rot_l[RES_W-1:OP_W]);
            MODE_ROR:  res_c = zext(rot_r[OP_W-1:0]);
            MODE_GT:   res_c = (in1 > in2)  ? RES_W'(1) : '0;
            MODE_EQ:   res_c = (in1 == in2) ? RES_W'(1) : '0;
            MODE_CLR:  res_c = '0;
            default:   res_c = '0;
        endcase
    end

endmodule

// File: rtl/top.sv
// Registered 4-bit ALU: one result per clock, synchronous active-high reset.
// Define TOP_MUL_EN to enable the multiply mode (otherwise it clears).
module top
    import top_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [OP_W-1:0]   in1,
    input  logic [OP_W-1:0]   in2,
    input  logic [MODE_W-1:0] alu_mode,
    output logic [RES_W-1:0]  out
);

    logic [RES_W-1:0] out_d;
    logic [RES_W-1:0] out_q;

    top_alu_core u_core (
        .in1      (in1),
        .in2      (in2),
        .alu_mode (alu_mode),
        .res_c    (out_d)
    );

    // Reset wins over any mode and discards the result computed this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_top.sv
// Self-checking bench for the registered ALU: directed vector table,
// hand-written reset sequences and random vectors against a reference model.
module tb_top;
    import top_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in1;
    logic [3:0] in2;
    logic [3:0] alu_mode;
    logic [7:0] out;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] exp;
        string      name;
    } sb_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] m;
        logic [7:0] exp;
        string      name;
    } vec_t;

    sb_t  sbq[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    top dut (
        .clk      (clk),
        .rst      (rst),
        .in1      (in1),
        .in2      (in2),
        .alu_mode (alu_mode),
        .out      (out)
    );

    // Independent integer reference model.
    function automatic logic [7:0] model(input int a, input int b, input int m);
        int r;
        int s;
        r = 0;
        s = b % 4;
        case (m)
            0:  r = a + b;
            1:  r = (a - b) & 255;
`ifdef TOP_MUL_EN
            2:  r = a * b;
`else
            2:  r = 0;
`endif
            3:  r = a & b;
            4:  r = a | b;
            5:  r = a ^ b;
            6:  r = (~(a & b)) & 15;
            7:  r = (~(a | b)) & 15;
            8:  r = (~(a ^ b)) & 15;
            9:  r = (a << (b % 8)) & 255;
            10: r = a >> s;
            11: r = ((a << s) | (a >> (4 - s))) & 15;
            12: r = ((a >> s) | (a << (4 - s))) & 15;
            13: r = (a > b) ? 1 : 0;
            14: r = (a == b) ? 1 : 0;
            default: r = 0;
        endcase
        return 8'(r);
    endfunction

    // Drive one operation at the falling edge and record its expected result.
    task automatic drive(input logic r, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] m, input logic [7:0] exp, input string name);
        sb_t e;
        @(negedge clk);
        rst      = r;
        in1      = a;
        in2      = b;
        alu_mode = m;
        e.exp    = exp;
        e.name   = name;
        sbq.push_back(e);
    endtask

    // Compare just after the capturing edge and again late in the same cycle.
    task automatic check_out();
        sb_t e;
        @(posedge clk);
        #1;
        checks++;
        if (sbq.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: out=%02h with no expected value", out);
        end else begin
            e = sbq.pop_front();
            if (out !== e.exp) begin
                failures++;
                $display("FAIL %s: got %02h expected %02h", e.name, out, e.exp);
            end
            #3;
            checks++;
            if (out !== e.exp) begin
                failures++;
                $display("FAIL %s_hold: got %02h expected %02h", e.name, out, e.exp);
            end
        end
    endtask

    task automatic step(input logic r, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] m, input logic [7:0] exp, input string name);
        drive(r, a, b, m, exp, name);
        check_out();
    endtask

    initial begin
        logic [7:0] mul_exp;
`ifdef TOP_MUL_EN
        mul_exp = 8'hE1;
`else
        mul_exp = 8'h00;
`endif
        rst = 1'b1; in1 = 4'h0; in2 = 4'h0; alu_mode = 4'h0;

        vecs.push_back('{4'd2,    4'd3,    MODE_ADD,  8'h05,   "add_2_3"});
        vecs.push_back('{4'd3,    4'd4,    MODE_SUB,  8'hFF,   "sub_3_4"});
        vecs.push_back('{4'hF,    4'hF,    MODE_ADD,  8'h1E,   "add_max"});
        vecs.push_back('{4'hF,    4'hF,    MODE_MUL,  mul_exp, "mul_max"});
        vecs.push_back('{4'b1100, 4'b1010, MODE_AND,  8'h08,   "and"});
        vecs.push_back('{4'b1100, 4'b1010, MODE_OR,   8'h0E,   "or"});
        vecs.push_back('{4'b1100, 4'b1010, MODE_XOR,  8'h06,   "xor"});
        vecs.push_back('{4'b1100, 4'b1010, MODE_NAND, 8'h07,   "nand"});
        vecs.push_back('{4'b1100, 4'b1010, MODE_NOR,  8'h01,   "nor"});
        vecs.push_back('{4'b1100, 4'b1010, MODE_XNOR, 8'h09,   "xnor"});
        vecs.push_back('{4'hF,    4'd4,    MODE_SHL,  8'hF0,   "shl_4"});
        vecs.push_back('{4'hF,    4'd15,   MODE_SHL,  8'h80,   "shl_upper_ignored"});
        vecs.push_back('{4'b1001, 4'd1,    MODE_SHR,  8'h04,   "shr_1"});
        vecs.push_back('{4'b1001, 4'd1,    MODE_ROL,  8'h03,   "rol_1"});
        vecs.push_back('{4'b1001, 4'd1,    MODE_ROR,  8'h0C,   "ror_1"});
        vecs.push_back('{4'b1001, 4'd5,    MODE_ROL,  8'h03,   "rol_upper_ignored"});
        vecs.push_back('{4'b1001, 4'd4,    MODE_ROR,  8'h09,   "ror_by_0"});
        vecs.push_back('{4'd5,    4'd5,    MODE_EQ,   8'h01,   "eq_5_5"});
        vecs.push_back('{4'd5,    4'd5,    MODE_GT,   8'h00,   "gt_5_5"});
        vecs.push_back('{4'd6,    4'd5,    MODE_GT,   8'h01,   "gt_6_5"});
        vecs.push_back('{4'd6,    4'd5,    MODE_EQ,   8'h00,   "eq_6_5"});
        vecs.push_back('{4'hA,    4'h7,    MODE_CLR,  8'h00,   "clr"});

        // Reset held two cycles with non-trivial inputs, then release.
        step(1'b1, 4'hF, 4'hF, MODE_ADD, 8'h00, "reset_cyc0");
        step(1'b1, 4'hF, 4'hF, MODE_ADD, 8'h00, "reset_cyc1");
        step(1'b0, 4'hF, 4'hF, MODE_ADD, 8'h1E, "first_after_reset");

        foreach (vecs[i]) begin
            step(1'b0, vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].exp, vecs[i].name);
        end

        // Reset in the middle of a run discards the pending result.
        step(1'b0, 4'd7, 4'd8, MODE_ADD, 8'h0F, "pre_midreset");
        step(1'b1, 4'd2, 4'd3, MODE_ADD, 8'h00, "midreset_discard");
        step(1'b0, 4'd3, 4'd4, MODE_SUB, 8'hFF, "post_midreset");

        // Random back-to-back operations against the model.
        for (int k = 0; k < 48; k++) begin
            logic [3:0] a;
            logic [3:0] b;
            logic [3:0] m;
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            m = 4'($urandom_range(0, 15));
            step(1'b0, a, b, m, model(int'(a), int'(b), int'(m)), "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
